// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
// Optional feature macro: MIPS_CTRL_BNE_EN adds the bne opcode and its BNE state.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
`ifdef MIPS_CTRL_BNE_EN
    ,
    BNE     = 4'd12
`endif
  } state_t;

  // Opcode field values (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  // ALUSrcB mux select.
  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // ALU operation class.
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  // PC source mux select.
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  // Moore control word decoded purely from the current state.
  typedef struct packed {
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       pc_write;
    logic       branch;     // PC loads when zero=1
    logic       branch_ne;  // PC loads when zero=0
  } ctrl_word_t;

endpackage

// File: rtl/mips_mc_ctrl_fsm_if.sv
// Control bus between the main FSM (master) and the multicycle datapath (slave).
interface mips_mc_ctrl_fsm_if #(
  parameter int OP_WIDTH   = 6,
  parameter int ICNT_WIDTH = 32
);
  logic [OP_WIDTH-1:0]   opcode;
  logic                  zero;
  logic                  iord;
  logic                  alu_src_a;
  logic [1:0]            alu_src_b;
  logic [1:0]            alu_op;
  logic                  reg_dst;
  logic                  mem_to_reg;
  logic [1:0]            pc_src;
  logic                  ir_write;
  logic                  mem_write;
  logic                  reg_write;
  logic                  pc_en;
  logic                  illegal_op;
  logic [ICNT_WIDTH-1:0] instr_count;

  modport master (
    input  opcode, zero,
    output iord, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, pc_src,
           ir_write, mem_write, reg_write, pc_en, illegal_op, instr_count
  );

  modport slave (
    output opcode, zero,
    input  iord, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, pc_src,
           ir_write, mem_write, reg_write, pc_en, illegal_op, instr_count
  );
endinterface

// File: rtl/mips_mc_ctrl_decode.sv
// Combinational state -> control-word decoder for the multicycle MIPS FSM.
// Optional feature macro: MIPS_CTRL_BNE_EN (decodes the BNE state).
module mips_mc_ctrl_decode
  import mips_mc_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t cw
);

  // Decode the Moore outputs of each state; anything not listed stays 0.
  always_comb begin
    // NOTE: every field gets a default first so no path leaves cw unassigned,
    // which is what keeps this block from inferring latches.
    cw = '0;
    case (state)
      FETCH: begin
        cw.ir_write  = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
        cw.alu_op    = ALU_ADD;
        cw.pc_src    = PC_ALU;
        cw.pc_write  = 1'b1;
      end
      DECODE: cw.alu_src_b = SRCB_IMM_SH;
      MEMADR, ADDIEX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
      end
      MEMRD:  cw.iord = 1'b1;
      MEMWB: begin
        cw.mem_to_reg = 1'b1;
        cw.reg_write  = 1'b1;
      end
      MEMWR: begin
        cw.iord      = 1'b1;
        cw.mem_write = 1'b1;
      end
      EXECUTE: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_REG;
        cw.alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        cw.reg_dst   = 1'b1;
        cw.reg_write = 1'b1;
      end
      BRANCH: begin
        cw.alu_src_a = 1'b1;
        cw.alu_op    = ALU_SUB;
        cw.pc_src    = PC_ALUOUT;
        cw.branch    = 1'b1;
      end
      ADDIWB: cw.reg_write = 1'b1;
      JUMP: begin
        cw.pc_src   = PC_JUMP;
        cw.pc_write = 1'b1;
      end
`ifdef MIPS_CTRL_BNE_EN
      BNE: begin
        cw.alu_src_a = 1'b1;
        cw.alu_op    = ALU_SUB;
        cw.pc_src    = PC_ALUOUT;
        cw.branch_ne = 1'b1;
      end
`endif
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl_fsm.sv
// Main control FSM for the multicycle MIPS datapath: state register,
// opcode-driven next-state logic, PC-enable gating and retired-instruction counter.
// Optional feature macro: MIPS_CTRL_BNE_EN (bne opcode 6'h05 via the BNE state).
module mips_mc_ctrl_fsm
  import mips_mc_pkg::*;
#(
  parameter int OP_WIDTH   = 6,
  parameter int ICNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_mc_ctrl_fsm_if.master   bus
);

  state_t                state_q, state_d;
  logic [ICNT_WIDTH-1:0] instr_count_q, instr_count_d;
  logic                  illegal;
  logic                  retire;
  ctrl_word_t            cw, cw_m;

  function automatic logic op_is(input logic [OP_WIDTH-1:0] op, input logic [5:0] code);
    return op == OP_WIDTH'(code);
  endfunction

  mips_mc_ctrl_decode u_decode (
    .state (state_q),
    .cw    (cw)
  );

  // Next state from current state and IR opcode; retire on the return to FETCH.
  always_comb begin
    state_d = FETCH;
    illegal = 1'b0;
    retire  = 1'b0;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        if (op_is(bus.opcode, OP_LW) || op_is(bus.opcode, OP_SW)) state_d = MEMADR;
        else if (op_is(bus.opcode, OP_RTYPE))                     state_d = EXECUTE;
        else if (op_is(bus.opcode, OP_BEQ))                       state_d = BRANCH;
        else if (op_is(bus.opcode, OP_ADDI))                      state_d = ADDIEX;
        else if (op_is(bus.opcode, OP_J))                         state_d = JUMP;
`ifdef MIPS_CTRL_BNE_EN
        else if (op_is(bus.opcode, OP_BNE))                       state_d = BNE;
`endif
        else                                                      illegal = 1'b1;
      end
      MEMADR:  state_d = op_is(bus.opcode, OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP: retire = 1'b1;
`ifdef MIPS_CTRL_BNE_EN
      BNE:     retire = 1'b1;
`endif
      default: state_d = FETCH;
    endcase
    instr_count_d = instr_count_q + (retire ? ICNT_WIDTH'(1) : '0);
  end

  // State and counter registers; synchronous reset has priority.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    if (reset) begin
      state_q       <= FETCH;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // While reset is high every select and enable reads 0, regardless of state.
  assign cw_m = reset ? '0 : cw;

  assign bus.iord        = cw_m.iord;
  assign bus.alu_src_a   = cw_m.alu_src_a;
  assign bus.alu_src_b   = cw_m.alu_src_b;
  assign bus.alu_op      = cw_m.alu_op;
  assign bus.reg_dst     = cw_m.reg_dst;
  assign bus.mem_to_reg  = cw_m.mem_to_reg;
  assign bus.pc_src      = cw_m.pc_src;
  assign bus.ir_write    = cw_m.ir_write;
  assign bus.mem_write   = cw_m.mem_write;
  assign bus.reg_write   = cw_m.reg_write;
  assign bus.pc_en       = cw_m.pc_write | (cw_m.branch & bus.zero) | (cw_m.branch_ne & ~bus.zero);
  assign bus.illegal_op  = illegal & ~reset;
  assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_mips_mc_ctrl_fsm.sv
// Self-checking bench for mips_mc_ctrl_fsm: per-instruction phase tables
// checked every cycle, directed corner cases plus a randomized instruction stream.
// Honours MIPS_CTRL_BNE_EN the same way the design does.
module tb_mips_mc_ctrl_fsm;

  localparam int ICNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  always #5 clk = ~clk;

  mips_mc_ctrl_fsm_if #(.OP_WIDTH(6), .ICNT_WIDTH(ICNT_W)) bus ();

  mips_mc_ctrl_fsm #(.OP_WIDTH(6), .ICNT_WIDTH(ICNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    bit ok;
    ok = (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) ||
         (op == 6'h04) || (op == 6'h08) || (op == 6'h02);
`ifdef MIPS_CTRL_BNE_EN
    ok = ok || (op == 6'h05);
`endif
    return ok;
  endfunction

  // Cycles per instruction, FETCH included; illegal ops end after DECODE.
  function automatic int latency(input logic [5:0] op);
    if (!is_legal(op))                return 2;
    if (op == 6'h23)                  return 5;
    if (op == 6'h04 || op == 6'h05 || op == 6'h02) return 3;
    return 4;
  endfunction

  // Expected outputs packed as {iord,src_a,src_b,alu_op,reg_dst,mem_to_reg,
  // pc_src,ir_write,mem_write,reg_write,pc_en,illegal_op}.
  function automatic logic [14:0] exp_out(input logic [5:0] op, input int ph, input logic z);
    logic iord, sa, rd, m2r, irw, mw, rw, pe, ill;
    logic [1:0] sb, ao, ps;
    {iord, sa, rd, m2r, irw, mw, rw, pe, ill} = '0;
    sb = 2'd0; ao = 2'd0; ps = 2'd0;
    if (ph == 0) begin
      irw = 1; sb = 2'd1; pe = 1;
    end else if (ph == 1) begin
      sb = 2'd3; ill = !is_legal(op);
    end else begin
      case (op)
        6'h23, 6'h2B: begin
          if (ph == 2) begin sa = 1; sb = 2'd2; end
          else if (ph == 3 && op == 6'h23) iord = 1;
          else if (ph == 3) begin iord = 1; mw = 1; end
          else begin m2r = 1; rw = 1; end
        end
        6'h00: if (ph == 2) begin sa = 1; ao = 2'd2; end else begin rd = 1; rw = 1; end
        6'h08: if (ph == 2) begin sa = 1; sb = 2'd2; end else rw = 1;
        6'h04, 6'h05: begin sa = 1; ao = 2'd1; ps = 2'd1; pe = (op == 6'h04) ? z : !z; end
        6'h02: begin ps = 2'd2; pe = 1; end
        default: ;
      endcase
    end
    return {iord, sa, sb, ao, rd, m2r, ps, irw, mw, rw, pe, ill};
  endfunction

  function automatic logic [14:0] got_out();
    return {bus.iord, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_dst,
            bus.mem_to_reg, bus.pc_src, bus.ir_write, bus.mem_write,
            bus.reg_write, bus.pc_en, bus.illegal_op};
  endfunction

  // Runs one instruction from FETCH; zsel 0/1 forces zero, 2 randomizes it per
  // cycle; abort_at >= 0 asserts reset in that phase and abandons the instruction.
  task automatic do_instr(input logic [5:0] op, input int zsel, input int abort_at);
    int lat;
    lat = latency(op);
    for (int p = 0; p < lat; p++) begin
      @(posedge clk); #1;
      reset      = (p == abort_at);
      bus.opcode = (p == 0) ? 6'($urandom) : op;
      bus.zero   = (zsel == 2) ? 1'($urandom) : (zsel == 1);
      @(negedge clk);
      if (reset) begin
        check($sformatf("rst_ctl op=%h ph=%0d", op, p), 32'(got_out()), 32'd0);
        check("rst_cnt", 32'(bus.instr_count), 32'(exp_cnt));
        exp_cnt = 0;
        return;
      end
      check($sformatf("ctl op=%h ph=%0d z=%0d", op, p, bus.zero),
            32'(got_out()), 32'(exp_out(op, p, bus.zero)));
      check($sformatf("cnt op=%h ph=%0d", op, p), 32'(bus.instr_count), 32'(exp_cnt));
    end
    if (is_legal(op)) exp_cnt = (exp_cnt + 1) % (1 << ICNT_W);
  endtask

  initial begin
    logic [5:0] ops [8];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02, 6'h3F};
    reset      = 1'b1;
    bus.opcode = '0;
    bus.zero   = 1'b0;

    // Two reset cycles: everything reads 0, counter cleared.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.opcode = 6'($urandom);
      bus.zero   = 1'($urandom);
      @(negedge clk);
      check("reset_ctl", 32'(got_out()), 32'd0);
      check("reset_cnt", 32'(bus.instr_count), 32'd0);
    end

    do_instr(6'h23, 2, -1);  // lw
    do_instr(6'h04, 1, -1);  // beq taken
    do_instr(6'h04, 0, -1);  // beq not taken
    do_instr(6'h3F, 2, -1);  // illegal
    do_instr(6'h2B, 2, 3);   // sw, reset during MEMWR
    for (int i = 0; i < 18; i++) do_instr(6'h02, 2, -1);  // j, wraps the counter
    do_instr(6'h05, 0, -1);  // bne with zero=0
    do_instr(6'h05, 1, -1);  // bne with zero=1

    for (int i = 0; i < 300; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      do_instr(op, 2, ($urandom_range(0, 49) == 0) ? $urandom_range(0, 1) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
